// File: rtl/rr_decode_arbiter_if.sv
// Request/grant bundle between the requesting masters and the round-robin
// decode arbiter. The master side drives requests and completion. The slave
// side (the arbiter) drives the decoder index/enable, the one-hot select and
// the status flags.
interface rr_decode_arbiter_if #(
  parameter int unsigned N    = 16,
  parameter int unsigned IDXW = 4
);
  logic [N-1:0]    req;
  logic            done;
  logic [IDXW-1:0] gnt_idx;
  logic            gnt_en;
  logic [N-1:0]    gnt_onehot;
  logic            busy;
  logic            timeout;

  modport master (
    output req, done,
    input  gnt_idx, gnt_en, gnt_onehot, busy, timeout
  );

  modport slave (
    input  req, done,
    output gnt_idx, gnt_en, gnt_onehot, busy, timeout
  );
endinterface

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter that feeds a downstream N-way decoder.
// - Drives the winner's index and an enable into the decoder.
// - Also drives a registered one-hot select.
// - A grant is held until the owner signals done or drops its request.
// - Every grant is followed by one dead RELEASE cycle with the enable low.
// Optional macro ARB_TIMEOUT_EN adds a saturating hold counter that forcibly
// revokes a grant after TIMEOUT cycles; without it, timeout is tied to 0.
module rr_decode_arbiter #(
  parameter int unsigned N       = 16,
  parameter int unsigned IDXW    = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  rr_decode_arbiter_if.slave bus
);

  if (N < 2 || N > 16 || (1 << IDXW) != N) begin : g_bad_size
    $error("rr_decode_arbiter: N must be a power of two in 2..16 and IDXW = log2(N)");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("rr_decode_arbiter: TIMEOUT must be in 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RELEASE
  } state_t;

  state_t          state;
  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] gnt_idx_q;
  logic            gnt_en_q;
  logic [N-1:0]    gnt_onehot_q;
  logic            busy_q;
  logic            timeout_q;

  logic [IDXW-1:0] winner;
  logic [IDXW-1:0] cand;
  logic            any_req;
  logic            exit_req;

  // Rotating priority search: first requester at or after ptr, wrapping mod N.
  always_comb begin
    winner  = '0;
    cand    = '0;
    any_req = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = ptr + IDXW'(k);
      if (!any_req && bus.req[cand]) begin
        winner  = cand;
        any_req = 1'b1;
      end
    end
  end

  // The owner finishing or withdrawing its request both end the grant.
  always_comb begin
    exit_req = bus.done || !bus.req[gnt_idx_q];
  end

`ifdef ARB_TIMEOUT_EN
  logic [15:0] hold_cnt;
  logic [15:0] hold_next;
  logic        expire;

  // The count including the current GRANT cycle. It saturates at all-ones.
  always_comb begin
    hold_next = (hold_cnt == '1) ? hold_cnt : hold_cnt + 16'd1;
    expire    = (hold_next == 16'(TIMEOUT));
  end
`endif

  // Arbitration FSM with registered decoder-facing outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      gnt_idx_q    <= '0;
      gnt_en_q     <= 1'b0;
      gnt_onehot_q <= '0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt     <= '0;
`endif
    end else begin
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_idx_q    <= winner;
            gnt_en_q     <= 1'b1;
            gnt_onehot_q <= N'(1) << winner;
            busy_q       <= 1'b1;
            state        <= GRANT;
`ifdef ARB_TIMEOUT_EN
            hold_cnt     <= '0;
`endif
          end
        end
        GRANT: begin
          if (exit_req) begin
            gnt_en_q     <= 1'b0;
            gnt_onehot_q <= '0;
            ptr          <= gnt_idx_q + IDXW'(1);
            state        <= RELEASE;
`ifdef ARB_TIMEOUT_EN
          end else if (expire) begin
            // A forced revoke takes the normal exit path but raises the timeout flag.
            gnt_en_q     <= 1'b0;
            gnt_onehot_q <= '0;
            ptr          <= gnt_idx_q + IDXW'(1);
            state        <= RELEASE;
            timeout_q    <= 1'b1;
          end else begin
            hold_cnt     <= hold_next;
`endif
          end
        end
        RELEASE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          gnt_en_q     <= 1'b0;
          gnt_onehot_q <= '0;
          busy_q       <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt_idx    = gnt_idx_q;
  assign bus.gnt_en     = gnt_en_q;
  assign bus.gnt_onehot = gnt_onehot_q;
  assign bus.busy       = busy_q;
  assign bus.timeout    = timeout_q;

  a_onehot_select: assert property (@(posedge clk) disable iff (rst)
    $onehot0(gnt_onehot_q) && ((gnt_onehot_q != '0) == gnt_en_q));

  a_select_matches_idx: assert property (@(posedge clk) disable iff (rst)
    gnt_en_q |-> (gnt_onehot_q == (N'(1) << gnt_idx_q)));

endmodule
